state_sequencer: RTL and testbench

//  Produces the 7-state one-hot state vector that the hex-display mapper consumes.
//  Bit i of state_out drives stateIn_i of the mapper.

---
 rtl/state_sequencer.sv | 145 ++++++++++++++
 tb/tb_state_sequencer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/state_sequencer.sv
// state_sequencer: key-driven 7-state one-hot sequencer for the hex-display mapper.
// Raw keys are synchronized and debounced. Each accepted press moves the one-hot state
// one step forward or backward, with wrap pulsing on any S6<->S0 transition.
// Optional feature macro: SEQ_AUTO_ADVANCE_EN builds a timed auto-advance driven by
// sw_auto. Without the macro, sw_auto is accepted but ignored.
// Event handshake: press events are single-cycle strobes with no back-pressure. The
// FSM consumes every event in the cycle that it is asserted.
module state_sequencer #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int AUTO_CYCLES     = 50000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_next_n,
  input  logic       key_prev_n,
  input  logic       sw_auto,
  output logic [6:0] state_out,
  output logic       wrap
);

  localparam int DW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DW-1:0] CNT_LAST = DW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [6:0] {
    S0 = 7'b0000001,
    S1 = 7'b0000010,
    S2 = 7'b0000100,
    S3 = 7'b0001000,
    S4 = 7'b0010000,
    S5 = 7'b0100000,
    S6 = 7'b1000000
  } state_t;

  // Index 0 is the next key and index 1 is the prev key. All of these are active-low levels.
  logic [1:0]    key_raw;
  logic [1:0]    sync1;
  logic [1:0]    sync2;
  logic [1:0]    deb;
  logic [1:0]    deb_dly;
  logic [DW-1:0] cnt [2];
  logic          ev_next;
  logic          ev_prev;
  logic          tick;

  state_t state_q;
  state_t state_d;
  logic   wrap_d;

  assign key_raw = {key_prev_n, key_next_n};

  // Two-flop synchronizers and per-key debounce. The accepted level only moves after
  // the synced level has differed for DEBOUNCE_CYCLES consecutive cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1   <= 2'b11;
      sync2   <= 2'b11;
      deb     <= 2'b11;
      deb_dly <= 2'b11;
      cnt[0]  <= '0;
      cnt[1]  <= '0;
    end else begin
      sync1   <= key_raw;
      sync2   <= sync1;
      deb_dly <= deb;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          deb[i] <= sync2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  // A press is the accepted level falling from 1 to 0. A release produces no event.
  assign ev_next = deb_dly[0] & ~deb[0];
  assign ev_prev = deb_dly[1] & ~deb[1];

`ifdef SEQ_AUTO_ADVANCE_EN
  localparam int AW = (AUTO_CYCLES > 2) ? $clog2(AUTO_CYCLES) : 1;
  localparam logic [AW-1:0] AUTO_LAST = AW'(AUTO_CYCLES - 1);

  logic          sw_s1;
  logic          sw_s2;
  logic [AW-1:0] timer;

  // A key event suppresses the tick in the same cycle, so the key step wins.
  assign tick = sw_s2 && (timer == AUTO_LAST) && !(ev_next || ev_prev);

  // Synchronize sw_auto and run the auto-advance timer. Any key event restarts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_s1 <= 1'b0;
      sw_s2 <= 1'b0;
      timer <= '0;
    end else begin
      sw_s1 <= sw_auto;
      sw_s2 <= sw_s1;
      if (ev_next || ev_prev || !sw_s2 || timer == AUTO_LAST) begin
        timer <= '0;
      end else begin
        timer <= timer + 1'b1;
      end
    end
  end
`else
  logic unused_sw_auto;
  assign unused_sw_auto = sw_auto;
  assign tick = 1'b0;
`endif

  // Next-state logic. Steps are rotations of the one-hot vector. Illegal codes recover to S0.
  always_comb begin
    state_d = state_q;
    wrap_d  = 1'b0;
    if (!$onehot(state_q)) begin
      state_d = S0;
    end else if (ev_next && ev_prev) begin
      state_d = state_q;
    end else if (ev_next || tick) begin
      state_d = state_t'({state_q[5:0], state_q[6]});
      wrap_d  = state_q[6];
    end else if (ev_prev) begin
      state_d = state_t'({state_q[0], state_q[6:1]});
      wrap_d  = state_q[0];
    end
  end

  // State and wrap are registered together so that wrap aligns with the state change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S0;
      wrap    <= 1'b0;
    end else begin
      state_q <= state_d;
      wrap    <= wrap_d;
    end
  end

  assign state_out = state_q;

endmodule

// File: tb/tb_state_sequencer.sv
// Bench for state_sequencer with DEBOUNCE_CYCLES=4 and AUTO_CYCLES=8.
// The reference model tracks the state as an index 0..6. A clean press moves it
// 7 edges after the raw key first goes low. Auto steps follow a precomputed edge schedule.
module tb_state_sequencer;

  localparam int DEB  = 4;
  localparam int AUTO = 8;
  localparam int LAT  = DEB + 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       key_next_n;
  logic       key_prev_n;
  logic       sw_auto;
  logic [6:0] state_out;
  logic       wrap;

  int checks   = 0;
  int failures = 0;
  int idx      = 0;
  bit exp_wrap = 1'b0;

  state_sequencer #(
    .DEBOUNCE_CYCLES(DEB),
    .AUTO_CYCLES    (AUTO)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_next_n(key_next_n),
    .key_prev_n(key_prev_n),
    .sw_auto   (sw_auto),
    .state_out (state_out),
    .wrap      (wrap)
  );

  // Clock generation.
  always #5 clk = ~clk;

  // Watchdog.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [6:0] onehot(input int i);
    logic [6:0] one;
    one = 7'd1;
    return one << i;
  endfunction

  // Reference step: plain modular arithmetic on the state index.
  task automatic model_step(input bit n, input bit p);
    exp_wrap = 1'b0;
    if (n && !p) begin
      exp_wrap = (idx == 6);
      idx = (idx + 1) % 7;
    end else if (p && !n) begin
      exp_wrap = (idx == 0);
      idx = (idx + 6) % 7;
    end
  endtask

  // Idle for n cycles with the keys released. Nothing may move.
  task automatic idle(input int n, input string tag);
    for (int e = 0; e < n; e++) begin
      @(negedge clk);
      checks++;
      if (state_out !== onehot(idx) || wrap !== 1'b0) begin
        failures++;
        $display("FAIL %s idle t=%0t state=%b wrap=%b want state=%b wrap=0",
                 tag, $time, state_out, wrap, onehot(idx));
      end
    end
  endtask

  // Press the key(s) for hold cycles (hold >= LAT+1), then release and idle.
  task automatic press(input bit n, input bit p, input int hold, input string tag);
    bit w;
    key_next_n = !n;
    key_prev_n = !p;
    for (int e = 1; e <= hold; e++) begin
      @(negedge clk);
      w = 1'b0;
      if (e == LAT) begin
        model_step(n, p);
        w = exp_wrap;
      end
      checks++;
      if (state_out !== onehot(idx) || wrap !== w) begin
        failures++;
        $display("FAIL %s edge%0d t=%0t state=%b wrap=%b want state=%b wrap=%b",
                 tag, e, $time, state_out, wrap, onehot(idx), w);
      end
    end
    key_next_n = 1'b1;
    key_prev_n = 1'b1;
    idle(12, tag);
  endtask

  task automatic test_reset_initial();
    checks++;
    if (state_out !== 7'b0000001 || wrap !== 1'b0) begin
      failures++;
      $display("FAIL reset_initial state=%b wrap=%b want 0000001/0", state_out, wrap);
    end
    @(negedge clk);
    rst_n = 1'b1;
    idle(20, "reset_idle");
  endtask

  task automatic test_forward_wrap();
    for (int k = 0; k < 7; k++) press(1'b1, 1'b0, 9, "forward");
    checks++;
    if (state_out !== 7'b0000001) begin
      failures++;
      $display("FAIL forward_end state=%b want 0000001", state_out);
    end
  endtask

  task automatic test_bounce();
    bit pat [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int e = 0; e < 7 + 12; e++) begin
      key_next_n = (e < 7) ? pat[e] : 1'b1;
      @(negedge clk);
      checks++;
      if (state_out !== onehot(idx) || wrap !== 1'b0) begin
        failures++;
        $display("FAIL bounce t=%0t state=%b wrap=%b want state=%b wrap=0",
                 $time, state_out, wrap, onehot(idx));
      end
    end
    press(1'b1, 1'b0, 40, "long_hold");
    checks++;
    if (state_out !== 7'b0000010) begin
      failures++;
      $display("FAIL long_hold_end state=%b want 0000010", state_out);
    end
  endtask

  task automatic test_backward_simultaneous();
    while (idx != 0) press(1'b0, 1'b1, 9, "back_to_s0");
    press(1'b0, 1'b1, 9, "prev_wrap");
    checks++;
    if (state_out !== 7'b1000000) begin
      failures++;
      $display("FAIL prev_wrap_end state=%b want 1000000", state_out);
    end
    press(1'b1, 1'b1, 9, "simultaneous");
    checks++;
    if (state_out !== 7'b1000000) begin
      failures++;
      $display("FAIL simultaneous_end state=%b want 1000000", state_out);
    end
  endtask

  task automatic test_random();
    int sel;
    for (int k = 0; k < 12; k++) begin
      sel = $urandom_range(0, 2);
      press(sel != 1, sel != 0, $urandom_range(LAT + 1, LAT + 14), "random");
      idle($urandom_range(0, 8), "random_gap");
    end
  endtask

`ifdef SEQ_AUTO_ADVANCE_EN
  task automatic test_auto();
    int  sched[$];
    bit  stepped;
    // Auto steps: the first at edge 10 (2 sync + 8 timer), then every 8 edges.
    // A next press at edge 63 steps at 69 and restarts the spacing (77, 85).
    sched = '{10, 18, 26, 34, 42, 50, 58, 66, 69, 77, 85};
    sw_auto = 1'b1;
    for (int e = 1; e <= 85; e++) begin
      @(negedge clk);
      stepped = 1'b0;
      if (sched.size() > 0 && sched[0] == e) begin
        void'(sched.pop_front());
        model_step(1'b1, 1'b0);
        stepped = exp_wrap;
      end
      checks++;
      if (state_out !== onehot(idx) || wrap !== stepped) begin
        failures++;
        $display("FAIL auto edge%0d state=%b wrap=%b want state=%b wrap=%b",
                 e, state_out, wrap, onehot(idx), stepped);
      end
      if (e == 62) key_next_n = 1'b0;
      if (e == 72) key_next_n = 1'b1;
    end
    sw_auto = 1'b0;
    idle(12, "auto_off");
  endtask
`else
  task automatic test_auto();
    sw_auto = 1'b1;
    idle(100, "auto_ignored");
    sw_auto = 1'b0;
    idle(4, "auto_ignored");
  endtask
`endif

  task automatic test_reset_mid();
    if (idx == 0) press(1'b1, 1'b0, 9, "pre_reset");
    key_next_n = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    idx = 0;
    checks++;
    if (state_out !== 7'b0000001 || wrap !== 1'b0) begin
      failures++;
      $display("FAIL reset_async state=%b wrap=%b want 0000001/0", state_out, wrap);
    end
    key_next_n = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    idle(20, "reset_mid_idle");
    press(1'b1, 1'b0, 9, "post_reset_press");
    checks++;
    if (state_out !== 7'b0000010) begin
      failures++;
      $display("FAIL post_reset_end state=%b want 0000010", state_out);
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    key_next_n = 1'b1;
    key_prev_n = 1'b1;
    sw_auto    = 1'b0;
    #23;
    test_reset_initial();
    test_forward_wrap();
    test_bounce();
    test_backward_simultaneous();
    test_random();
    test_auto();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
